dmem_arbiter: RTL and testbench

Two-master arbiter for the single-port data memory. Master 0 is the CPU controller's data-memory interface (load/store states). Master 1 is the program/data loader and debug port. The block grants one single-beat access per cycle using round-robin arbitration, and supports a bounded locked burst so that a loader can stream without being starved or starving the CPU. Read data returns one cycle after grant, which matches the synchronous data RAM.

---
 rtl/dmem_arbiter.sv | 143 ++++++++++++++
 tb/tb_dmem_arbiter.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// Two-master round-robin arbiter for the single-port data RAM.
// Supports bounded locked bursts; read data returns one cycle after grant.
module dmem_arbiter #(
  parameter int AW        = 8,
  parameter int DW        = 16,
  parameter int MAX_BURST = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          m0_req,
  input  logic          m0_we,
  input  logic          m0_lock,
  input  logic [AW-1:0] m0_addr,
  input  logic [DW-1:0] m0_wdata,
  output logic          m0_gnt,
  output logic          m0_rvalid,
  output logic [DW-1:0] m0_rdata,
  input  logic          m1_req,
  input  logic          m1_we,
  input  logic          m1_lock,
  input  logic [AW-1:0] m1_addr,
  input  logic [DW-1:0] m1_wdata,
  output logic          m1_gnt,
  output logic          m1_rvalid,
  output logic [DW-1:0] m1_rdata,
  output logic [AW-1:0] mem_addr,
  output logic          mem_rd,
  output logic          mem_wr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic [1:0]    owner
);

  localparam int CW = $clog2(MAX_BURST + 1);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    OWN0 = 2'b01,
    OWN1 = 2'b10
  } state_t;

  state_t        state, state_nx;
  logic          last, last_nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic          rv0, rv1;
  logic          g0, g1;
  logic          sat;

  assign sat = (cnt == CW'(MAX_BURST));

  // Owner keeps the slot unless its burst is spent and the other waits.
  always_comb begin
    g0 = 1'b0;
    g1 = 1'b0;
    if (!rst) begin
      if (state == OWN0 && m0_req) begin
        if (sat && m1_req) g1 = 1'b1;
        else               g0 = 1'b1;
      end else if (state == OWN1 && m1_req) begin
        if (sat && m0_req) g0 = 1'b1;
        else               g1 = 1'b1;
      end else if (m0_req && m1_req) begin
        if (last) g0 = 1'b1;
        else      g1 = 1'b1;
      end else begin
        g0 = m0_req;
        g1 = m1_req;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      last  <= 1'b1;
      cnt   <= '0;
      rv0   <= 1'b0;
      rv1   <= 1'b0;
    end else begin
      state <= state_nx;
      last  <= last_nx;
      cnt   <= cnt_nx;
      rv0   <= g0 & ~m0_we;
      rv1   <= g1 & ~m1_we;
    end
  end

  always_comb begin
    state_nx = IDLE;
    cnt_nx   = '0;
    last_nx  = last;
    unique case (1'b1)
      g0: begin
        last_nx  = 1'b0;
        state_nx = m0_lock ? OWN0 : IDLE;
        if (state == OWN0)
          cnt_nx = sat ? cnt : cnt + CW'(1);
        else
          cnt_nx = CW'(1);
      end
      g1: begin
        last_nx  = 1'b1;
        state_nx = m1_lock ? OWN1 : IDLE;
        if (state == OWN1)
          cnt_nx = sat ? cnt : cnt + CW'(1);
        else
          cnt_nx = CW'(1);
      end
      default: ;
    endcase
  end

  always_comb begin
    mem_addr  = '0;
    mem_wdata = '0;
    mem_rd    = 1'b0;
    mem_wr    = 1'b0;
    unique case (1'b1)
      g0: begin
        mem_addr  = m0_addr;
        mem_wdata = m0_wdata;
        mem_wr    = m0_we;
        mem_rd    = ~m0_we;
      end
      g1: begin
        mem_addr  = m1_addr;
        mem_wdata = m1_wdata;
        mem_wr    = m1_we;
        mem_rd    = ~m1_we;
      end
      default: ;
    endcase
  end

  assign m0_gnt    = g0;
  assign m1_gnt    = g1;
  assign m0_rvalid = rv0 & ~rst;
  assign m1_rvalid = rv1 & ~rst;
  assign m0_rdata  = m0_rvalid ? mem_rdata : '0;
  assign m1_rdata  = m1_rvalid ? mem_rdata : '0;
  assign owner     = state;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a RAM model and a
// per-master read-data scoreboard.
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        m0_req, m0_we, m0_lock;
  logic [7:0]  m0_addr;
  logic [15:0] m0_wdata;
  logic        m0_gnt, m0_rvalid;
  logic [15:0] m0_rdata;
  logic        m1_req, m1_we, m1_lock;
  logic [7:0]  m1_addr;
  logic [15:0] m1_wdata;
  logic        m1_gnt, m1_rvalid;
  logic [15:0] m1_rdata;
  logic [7:0]  mem_addr;
  logic        mem_rd, mem_wr;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;
  logic [1:0]  owner;

  logic [15:0] ram    [256];
  logic [15:0] shadow [256];
  logic [15:0] q0[$];
  logic [15:0] q1[$];
  logic        pend0 = 1'b0;
  logic        pend1 = 1'b0;
  int          checks = 0;
  int          passed = 0;
  int          failed = 0;

  always #5 clk = ~clk;

  dmem_arbiter #(.AW(8), .DW(16), .MAX_BURST(4)) dut (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_we(m0_we), .m0_lock(m0_lock),
    .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_lock(m1_lock),
    .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
    .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_wr(mem_wr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .owner(owner)
  );

  always @(posedge clk) begin
    if (mem_wr) ram[mem_addr] <= mem_wdata;
    if (mem_rd) mem_rdata <= ram[mem_addr];
  end

  function automatic void chk(string tag, logic [31:0] obs,
                              logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endfunction

  // One clock cycle: inputs already driven, check at negedge.
  task automatic cyc(input logic eg0, input logic eg1,
                     input logic [1:0] eown, input bit co);
    logic [15:0] e;
    @(negedge clk);
    chk("m0_gnt", 32'(m0_gnt), 32'(eg0));
    chk("m1_gnt", 32'(m1_gnt), 32'(eg1));
    if (co) chk("owner", 32'(owner), 32'(eown));
    chk("mem_rd", 32'(mem_rd),
        32'((eg0 & ~m0_we) | (eg1 & ~m1_we)));
    chk("mem_wr", 32'(mem_wr),
        32'((eg0 & m0_we) | (eg1 & m1_we)));
    chk("mem_addr", 32'(mem_addr),
        32'(eg0 ? m0_addr : eg1 ? m1_addr : 8'h00));
    chk("mem_wdata", 32'(mem_wdata),
        32'(eg0 ? m0_wdata : eg1 ? m1_wdata : 16'h0));
    chk("m0_rvalid", 32'(m0_rvalid), 32'(pend0 & ~rst));
    chk("m1_rvalid", 32'(m1_rvalid), 32'(pend1 & ~rst));
    if (pend0) begin
      e = q0.pop_front();
      chk("m0_rdata", 32'(m0_rdata), 32'(rst ? 16'h0 : e));
    end else begin
      chk("m0_rdata", 32'(m0_rdata), 32'h0);
    end
    if (pend1) begin
      e = q1.pop_front();
      chk("m1_rdata", 32'(m1_rdata), 32'(rst ? 16'h0 : e));
    end else begin
      chk("m1_rdata", 32'(m1_rdata), 32'h0);
    end
    pend0 = eg0 & ~m0_we;
    pend1 = eg1 & ~m1_we;
    if (pend0) q0.push_back(shadow[m0_addr]);
    if (pend1) q1.push_back(shadow[m1_addr]);
    if (eg0 & m0_we) shadow[m0_addr] = m0_wdata;
    if (eg1 & m1_we) shadow[m1_addr] = m1_wdata;
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      ram[i]    = 16'(i * 3 + 1);
      shadow[i] = 16'(i * 3 + 1);
    end
    ram[8'h10] = 16'hBEEF;  shadow[8'h10] = 16'hBEEF;
    ram[8'h11] = 16'h5A5A;  shadow[8'h11] = 16'h5A5A;
    rst = 1'b1;
    m0_req = 0; m0_we = 0; m0_lock = 0; m0_addr = 0; m0_wdata = 0;
    m1_req = 0; m1_we = 0; m1_lock = 0; m1_addr = 0; m1_wdata = 0;
    repeat (2) @(posedge clk);
    #1;

    // Requests are ignored while reset is held
    m0_req = 1; m0_addr = 8'h10;
    cyc(0, 0, 2'b00, 1);

    // Read return
    rst = 0;
    cyc(1, 0, 2'b00, 1);
    m0_req = 0;
    cyc(0, 0, 2'b00, 1);

    // Round-robin tie after reset
    rst = 1;
    cyc(0, 0, 2'b00, 1);
    rst = 0;
    m0_req = 1; m0_addr = 8'h01;
    m1_req = 1; m1_addr = 8'h02;
    cyc(1, 0, 2'b00, 1);
    cyc(0, 1, 2'b00, 1);
    cyc(1, 0, 2'b00, 1);
    cyc(0, 1, 2'b00, 1);
    m0_req = 0; m1_req = 0;
    cyc(0, 0, 2'b00, 1);

    // Forced preemption of a locked write burst
    m0_req = 1; m0_we = 1; m0_lock = 1;
    m1_req = 1; m1_we = 0; m1_addr = 8'h31;
    for (int i = 0; i < 4; i++) begin
      m0_addr  = 8'(8'h30 + i);
      m0_wdata = 16'(16'hA000 + i);
      cyc(1, 0, (i == 0) ? 2'b00 : 2'b01, 1);
    end
    m0_addr = 8'h34; m0_wdata = 16'hA004;
    cyc(0, 1, 2'b01, 1);
    m1_req = 0;
    cyc(1, 0, 2'b00, 1);
    m0_addr = 8'h35; m0_wdata = 16'hA005; m0_lock = 0;
    cyc(1, 0, 2'b01, 1);
    m0_req = 0; m0_we = 0;
    cyc(0, 0, 2'b00, 1);

    // Lock release hands the slot over in the same cycle
    m0_req = 1; m0_lock = 1; m0_addr = 8'h10;
    cyc(1, 0, 2'b00, 1);
    m0_req = 0; m0_lock = 0;
    m1_req = 1; m1_addr = 8'h34;
    cyc(0, 1, 2'b01, 1);
    m1_req = 0;
    cyc(0, 0, 2'b00, 1);

    // Write path, then read it back
    m1_req = 1; m1_we = 1; m1_addr = 8'h22; m1_wdata = 16'h1234;
    cyc(0, 1, 2'b00, 1);
    m1_req = 0; m1_we = 0;
    cyc(0, 0, 2'b00, 1);
    m0_req = 1; m0_addr = 8'h22;
    cyc(1, 0, 2'b00, 1);
    m0_req = 0;
    cyc(0, 0, 2'b00, 1);

    // Reset in the middle of a locked m1 read burst
    m1_req = 1; m1_lock = 1; m1_addr = 8'h10;
    cyc(0, 1, 2'b00, 1);
    m1_addr = 8'h11;
    cyc(0, 1, 2'b10, 1);
    rst = 1; m0_req = 1; m0_addr = 8'h10;
    cyc(0, 0, 2'b00, 0);
    cyc(0, 0, 2'b00, 1);
    rst = 0; m1_lock = 0;
    cyc(1, 0, 2'b00, 1);
    m0_req = 0;
    cyc(0, 1, 2'b00, 1);
    m1_req = 0;
    cyc(0, 0, 2'b00, 1);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
